// File: rtl/osd_dii_type_demux.sv
// N-way DI packet demultiplexer: buffers the header up to a classification flit,
// routes the packet to the first value/mask match, then cuts the payload through.
package osd_dii_type_demux_pkg;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;
endpackage

module osd_dii_type_demux
  import osd_dii_type_demux_pkg::*;
#(
  parameter int unsigned           NUM_OUT     = 2,
  parameter int unsigned           MATCH_FLIT  = 2,
  parameter logic [NUM_OUT*16-1:0] MATCH_VALUE = '0,
  parameter logic [NUM_OUT*16-1:0] MATCH_MASK  = (NUM_OUT*16)'(32'h0000_C000),
  parameter int unsigned           DEFAULT_OUT = NUM_OUT - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  dii_flit            in,
  output logic               in_ready,
  output dii_flit            out [NUM_OUT],
  input  logic [NUM_OUT-1:0] out_ready
);

  localparam int unsigned CW = (MATCH_FLIT > 0) ? $clog2(MATCH_FLIT + 1) : 1;
  localparam int unsigned SW = $clog2(NUM_OUT);
  localparam int unsigned HD = MATCH_FLIT + 1;

  if (NUM_OUT < 2) begin : g_bad_num_out
    $error("osd_dii_type_demux: NUM_OUT must be at least 2");
  end
  if (DEFAULT_OUT >= NUM_OUT) begin : g_bad_default_out
    $error("osd_dii_type_demux: DEFAULT_OUT must be below NUM_OUT");
  end
  if (MATCH_FLIT > 15) begin : g_bad_match_flit
    $error("osd_dii_type_demux: MATCH_FLIT must not exceed 15");
  end

  typedef enum logic [1:0] {
    S_HDR,
    S_DRAIN,
    S_PASS
  } state_t;

  state_t        state, state_n;
  logic [15:0]   hbuf [HD];
  logic [CW-1:0] cnt, rptr, hend;
  logic          hlast;
  logic [SW-1:0] sel, match_sel;
  logic          hdr_take, drain_take, pass_take;

  // Lowest-index port whose masked value matches the incoming flit.
  always_comb begin
    match_sel = SW'(DEFAULT_OUT);
    for (int i = int'(NUM_OUT) - 1; i >= 0; i--) begin
      if ((in.data & MATCH_MASK[i*16 +: 16]) ==
          (MATCH_VALUE[i*16 +: 16] & MATCH_MASK[i*16 +: 16])) begin
        match_sel = SW'(i);
      end
    end
  end

  // Next-state and handshake outputs; everything is held idle while in reset.
  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    hdr_take   = 1'b0;
    drain_take = 1'b0;
    pass_take  = 1'b0;
    for (int p = 0; p < int'(NUM_OUT); p++) begin
      out[p] = '0;
    end
    if (!rst) begin
      unique case (state)
        S_HDR: begin
          in_ready = 1'b1;
          hdr_take = in.valid;
          if (hdr_take && ((cnt == CW'(MATCH_FLIT)) || in.last)) begin
            state_n = S_DRAIN;
          end
        end
        S_DRAIN: begin
          out[sel].data  = hbuf[rptr];
          out[sel].last  = hlast && (rptr == hend);
          out[sel].valid = 1'b1;
          drain_take     = out_ready[sel];
          if (drain_take && (rptr == hend)) begin
            state_n = hlast ? S_HDR : S_PASS;
          end
        end
        S_PASS: begin
          out[sel]  = in;
          in_ready  = out_ready[sel];
          pass_take = in.valid && out_ready[sel];
          if (pass_take && in.last) begin
            state_n = S_HDR;
          end
        end
        default: state_n = S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HDR;
      cnt   <= '0;
      rptr  <= '0;
      hend  <= '0;
      hlast <= 1'b0;
      sel   <= SW'(DEFAULT_OUT);
    end else begin
      state <= state_n;
      if (hdr_take) begin
        if (cnt == CW'(MATCH_FLIT)) begin
          sel   <= match_sel;
          hend  <= cnt;
          hlast <= in.last;
        end else if (in.last) begin
          // Packet ended before the classification flit.
          sel   <= SW'(DEFAULT_OUT);
          hend  <= cnt;
          hlast <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      if (drain_take) begin
        if (rptr == hend) begin
          rptr <= '0;
          cnt  <= '0;
        end else begin
          rptr <= rptr + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_take) begin
      hbuf[cnt] <= in.data;
    end
  end

endmodule
